control_unit: RTL and testbench

- Multicycle control FSM that drives every control input of the CPU datapath.
- Consumes the decoded instruction fields and ALU status flags; produces write enables, mux selects and ALU operation codes.
- One instruction at a time; memory accesses include a configurable number of wait cycles.
- Handles invalid-opcode and arithmetic-overflow exceptions by saving the faulting PC in EPC and vectoring to a handler.

---
 rtl/cpu_ctrl_pkg.sv | 64 ++++++
 rtl/control_unit.sv | 195 +++++++++++++++++++
 tb/tb_control_unit.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle CPU control unit.
// Holds opcode/FUNCT constants, datapath mux/ALU encodings and FSM state codes.
// Imported by control_unit and by anything that needs to decode state_dbg.
package cpu_ctrl_pkg;

    // Instruction opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type FUNCT codes (IR[5:0])
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;

    // ALUControl
    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;

    // AluSrcB
    localparam logic [3:0] SRCB_B       = 4'd0;
    localparam logic [3:0] SRCB_FOUR    = 4'd1;
    localparam logic [3:0] SRCB_SEXT    = 4'd2;
    localparam logic [3:0] SRCB_SEXT_SH = 4'd3;

    // PCSource
    localparam logic [3:0] PCS_ALURES = 4'd0;
    localparam logic [3:0] PCS_ALUOUT = 4'd1;
    localparam logic [3:0] PCS_JUMP   = 4'd2;
    localparam logic [3:0] PCS_EPC    = 4'd3;
    localparam logic [3:0] PCS_EXCVEC = 4'd4;

    // WriteSrc
    localparam logic [3:0] WS_ALUOUT = 4'd0;
    localparam logic [3:0] WS_HI     = 4'd1;
    localparam logic [3:0] WS_LO     = 4'd2;

    // Exception select; the datapath turns these into the vector byte addresses below
    localparam logic [3:0] EXC_NONE   = 4'd0;
    localparam logic [3:0] EXC_OPCODE = 4'd1;
    localparam logic [3:0] EXC_OVERFL = 4'd2;

    localparam int EXC_OPCODE_ADDR = 253;
    localparam int EXC_OVF_ADDR    = 254;

    // The exception path is split by cause so the Exception select stays a pure
    // function of state (no separate cause register).
    typedef enum logic [4:0] {
        S_RST, S_FETCH, S_F_WAIT, S_IR_LD, S_DECODE,
        S_EXEC_R, S_EXEC_I, S_WB_R, S_WB_I,
        S_ADDR, S_LW_RD, S_LW_WAIT, S_LW_WB, S_SW_WR,
        S_BRANCH, S_JUMP, S_JR,
        S_EXC_OP, S_EXC_OVF, S_EPC_OP, S_EPC_OVF, S_EWAIT_OP, S_EWAIT_OVF,
        S_EXC_JMP
    } state_t;

endpackage

// File: rtl/control_unit.sv
// Multicycle CPU control FSM: decodes OPCODE/FUNCT and ALU flags into datapath controls.
// Ports: clk, reset (sync, active low), OPCODE/FUNCT/Overflow/Zero in; enables, selects, state_dbg out.
// Latency: one state per cycle, memory states held MEM_WAIT cycles; no backpressure, one instruction at a time.
module control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OPCODE,
    input  logic [5:0] FUNCT,
    input  logic       Overflow,
    input  logic       Zero,
    output logic       PCwrite,
    output logic       MemWrite,
    output logic       MemRead,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       EPCWrite,
    output logic       MemToReg,
    output logic       RegDest,
    output logic       AluSrcA,
    output logic       IorD,
    output logic       ExceptionOcurred,
    output logic [3:0] AluSrcB,
    output logic [3:0] PCSource,
    output logic [3:0] WriteSrc,
    output logic [3:0] Exception,
    output logic [2:0] ALUControl,
    output logic [4:0] state_dbg
);

    // Wait states exit on the last count; SW_WR is held one extra cycle.
    localparam logic [1:0] WAIT_LAST = 2'(MEM_WAIT - 1);
    localparam logic [1:0] SW_LAST   = 2'(MEM_WAIT);

    state_t     state, state_nxt;
    logic [1:0] cnt;

    assign state_dbg = state;

    // Next-state decision
    always_comb begin
        state_nxt = state;
        case (state)
            S_RST:    state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_F_WAIT;
            S_F_WAIT: if (cnt == WAIT_LAST) state_nxt = S_IR_LD;
            S_IR_LD:  state_nxt = S_DECODE;
            S_DECODE: begin
                case (OPCODE)
                    OP_RTYPE: begin
                        case (FUNCT)
                            FN_ADD, FN_SUB, FN_AND: state_nxt = S_EXEC_R;
                            FN_JR:                  state_nxt = S_JR;
                            default:                state_nxt = S_EXC_OP;
                        endcase
                    end
                    OP_ADDI:        state_nxt = S_EXEC_I;
                    OP_LW, OP_SW:   state_nxt = S_ADDR;
                    OP_BEQ, OP_BNE: state_nxt = S_BRANCH;
                    OP_J:           state_nxt = S_JUMP;
                    default:        state_nxt = S_EXC_OP;
                endcase
            end
            // `and` cannot overflow, so only add/sub divert to the exception path
            S_EXEC_R: state_nxt = (Overflow && (FUNCT == FN_ADD || FUNCT == FN_SUB))
                                  ? S_EXC_OVF : S_WB_R;
            S_EXEC_I:  state_nxt = Overflow ? S_EXC_OVF : S_WB_I;
            S_ADDR:    state_nxt = (OPCODE == OP_SW) ? S_SW_WR : S_LW_RD;
            S_LW_RD:   state_nxt = S_LW_WAIT;
            S_LW_WAIT: if (cnt == WAIT_LAST) state_nxt = S_LW_WB;
            S_SW_WR:   if (cnt == SW_LAST) state_nxt = S_FETCH;
            S_EXC_OP:  state_nxt = S_EPC_OP;
            S_EXC_OVF: state_nxt = S_EPC_OVF;
            S_EPC_OP:  state_nxt = S_EWAIT_OP;
            S_EPC_OVF: state_nxt = S_EWAIT_OVF;
            S_EWAIT_OP, S_EWAIT_OVF: if (cnt == WAIT_LAST) state_nxt = S_EXC_JMP;
            S_WB_R, S_WB_I, S_LW_WB, S_BRANCH, S_JUMP, S_JR, S_EXC_JMP:
                state_nxt = S_FETCH;
            default:   state_nxt = S_RST;
        endcase
    end

    // State register and wait counter; the counter restarts whenever the state changes
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_RST;
            cnt   <= 2'd0;
        end else begin
            state <= state_nxt;
            cnt   <= (state_nxt == state) ? cnt + 2'd1 : 2'd0;
        end
    end

    // Output decode. Gated by reset so a write already decoded for the current
    // state is suppressed during the cycle reset is being sampled.
    always_comb begin
        PCwrite          = 1'b0;
        MemWrite         = 1'b0;
        MemRead          = 1'b0;
        IRWrite          = 1'b0;
        RegWrite         = 1'b0;
        EPCWrite         = 1'b0;
        MemToReg         = 1'b0;
        RegDest          = 1'b0;
        AluSrcA          = 1'b0;
        IorD             = 1'b0;
        ExceptionOcurred = 1'b0;
        AluSrcB          = SRCB_B;
        PCSource         = PCS_ALURES;
        WriteSrc         = WS_ALUOUT;
        Exception        = EXC_NONE;
        ALUControl       = ALU_PASS;
        if (reset) begin
            case (state)
                S_FETCH: begin
                    MemRead    = 1'b1;
                    AluSrcB    = SRCB_FOUR;
                    ALUControl = ALU_ADD;
                    PCwrite    = 1'b1;
                end
                S_IR_LD: IRWrite = 1'b1;
                S_DECODE: begin
                    AluSrcB    = SRCB_SEXT_SH;
                    ALUControl = ALU_ADD;
                end
                S_EXEC_R: begin
                    AluSrcA = 1'b1;
                    case (FUNCT)
                        FN_SUB:  ALUControl = ALU_SUB;
                        FN_AND:  ALUControl = ALU_AND;
                        default: ALUControl = ALU_ADD;
                    endcase
                end
                S_EXEC_I, S_ADDR: begin
                    AluSrcA    = 1'b1;
                    AluSrcB    = SRCB_SEXT;
                    ALUControl = ALU_ADD;
                end
                S_WB_R: begin
                    RegWrite = 1'b1;
                    RegDest  = 1'b1;
                end
                S_WB_I: RegWrite = 1'b1;
                S_LW_RD: begin
                    IorD    = 1'b1;
                    MemRead = 1'b1;
                end
                S_LW_WB: begin
                    RegWrite = 1'b1;
                    MemToReg = 1'b1;
                end
                S_SW_WR: begin
                    IorD     = 1'b1;
                    MemWrite = 1'b1;
                end
                S_BRANCH: begin
                    AluSrcA    = 1'b1;
                    ALUControl = ALU_SUB;
                    PCSource   = PCS_ALUOUT;
                    PCwrite    = (OPCODE == OP_BNE) ? !Zero : Zero;
                end
                S_JUMP: begin
                    PCSource = PCS_JUMP;
                    PCwrite  = 1'b1;
                end
                S_JR: begin
                    AluSrcA = 1'b1;
                    PCwrite = 1'b1;
                end
                S_EXC_OP, S_EXC_OVF: begin
                    AluSrcB    = SRCB_FOUR;
                    ALUControl = ALU_SUB;
                end
                S_EPC_OP, S_EPC_OVF: begin
                    EPCWrite  = 1'b1;
                    IorD      = 1'b1;
                    MemRead   = 1'b1;
                    Exception = (state == S_EPC_OP) ? EXC_OPCODE : EXC_OVERFL;
                end
                S_EWAIT_OP:  Exception = EXC_OPCODE;
                S_EWAIT_OVF: Exception = EXC_OVERFL;
                S_EXC_JMP: begin
                    PCSource         = PCS_EXCVEC;
                    ExceptionOcurred = 1'b1;
                    PCwrite          = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: one instance with MEM_WAIT=1 (a_*) and one with MEM_WAIT=2 (b_*).
// Each instruction runs from FETCH until FETCH recurs while per-cycle events are tallied.
// Tallies are compared against hand-derived cycle counts and control values.
module tb_control_unit;
    import cpu_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] opcode = 6'h0;
    logic [5:0] funct = 6'h0;
    logic       ovf = 1'b0;
    logic       zero = 1'b0;

    always #5 clk = ~clk;

    logic       a_pcw, a_mw, a_mr, a_irw, a_rw, a_epcw, a_m2r, a_rd, a_srca, a_iord, a_exo;
    logic [3:0] a_srcb, a_psrc, a_wsrc, a_exc;
    logic [2:0] a_alu;
    logic [4:0] a_st;
    logic       b_pcw, b_mw, b_mr, b_irw, b_rw, b_epcw, b_m2r, b_rd, b_srca, b_iord, b_exo;
    logic [3:0] b_srcb, b_psrc, b_wsrc, b_exc;
    logic [2:0] b_alu;
    logic [4:0] b_st;

    control_unit #(.MEM_WAIT(1)) dut_a (
        .clk(clk), .reset(reset), .OPCODE(opcode), .FUNCT(funct), .Overflow(ovf), .Zero(zero),
        .PCwrite(a_pcw), .MemWrite(a_mw), .MemRead(a_mr), .IRWrite(a_irw), .RegWrite(a_rw),
        .EPCWrite(a_epcw), .MemToReg(a_m2r), .RegDest(a_rd), .AluSrcA(a_srca), .IorD(a_iord),
        .ExceptionOcurred(a_exo), .AluSrcB(a_srcb), .PCSource(a_psrc), .WriteSrc(a_wsrc),
        .Exception(a_exc), .ALUControl(a_alu), .state_dbg(a_st)
    );

    control_unit #(.MEM_WAIT(2)) dut_b (
        .clk(clk), .reset(reset), .OPCODE(opcode), .FUNCT(funct), .Overflow(ovf), .Zero(zero),
        .PCwrite(b_pcw), .MemWrite(b_mw), .MemRead(b_mr), .IRWrite(b_irw), .RegWrite(b_rw),
        .EPCWrite(b_epcw), .MemToReg(b_m2r), .RegDest(b_rd), .AluSrcA(b_srca), .IorD(b_iord),
        .ExceptionOcurred(b_exo), .AluSrcB(b_srcb), .PCSource(b_psrc), .WriteSrc(b_wsrc),
        .Exception(b_exc), .ALUControl(b_alu), .state_dbg(b_st)
    );

    wire [29:0] a_all = {a_pcw, a_mw, a_mr, a_irw, a_rw, a_epcw, a_m2r, a_rd, a_srca, a_iord,
                         a_exo, a_srcb, a_psrc, a_wsrc, a_exc, a_alu};
    wire [29:0] b_all = {b_pcw, b_mw, b_mr, b_irw, b_rw, b_epcw, b_m2r, b_rd, b_srca, b_iord,
                         b_exo, b_srcb, b_psrc, b_wsrc, b_exc, b_alu};

    // Selected instance view
    logic       sel = 1'b0;
    wire  [4:0] st   = sel ? b_st   : a_st;
    wire        pcw  = sel ? b_pcw  : a_pcw;
    wire        mw   = sel ? b_mw   : a_mw;
    wire        mr   = sel ? b_mr   : a_mr;
    wire        rw   = sel ? b_rw   : a_rw;
    wire        epcw = sel ? b_epcw : a_epcw;
    wire        m2r  = sel ? b_m2r  : a_m2r;
    wire        rd   = sel ? b_rd   : a_rd;
    wire        iord = sel ? b_iord : a_iord;
    wire        exo  = sel ? b_exo  : a_exo;
    wire  [3:0] srcb = sel ? b_srcb : a_srcb;
    wire  [3:0] psrc = sel ? b_psrc : a_psrc;
    wire  [3:0] exc  = sel ? b_exc  : a_exc;
    wire  [2:0] alu  = sel ? b_alu  : a_alu;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Leaves both instances in FETCH
    task automatic do_reset;
        reset = 1'b0;
        tick;
        tick;
        reset = 1'b1;
        tick;
    endtask

    int len, rw_n, rw_cyc, rw_rd, rw_m2r, mw_n, mw_first, mw_last, mw_iord, mr_n;
    int epc_n, epc_exc, xj_n, xj_ok, br_n, jp_n, jr_n, alu_c5, srcb_c4;

    task automatic run(input logic s, input logic [5:0] op, input logic [5:0] fn,
                       input logic o, input logic z);
        sel = s; opcode = op; funct = fn; ovf = o; zero = z;
        len = 0; rw_n = 0; rw_cyc = 0; rw_rd = 0; rw_m2r = 0; mw_n = 0; mw_first = 0;
        mw_last = 0; mw_iord = 0; mr_n = 0; epc_n = 0; epc_exc = 0; xj_n = 0; xj_ok = 0;
        br_n = 0; jp_n = 0; jr_n = 0; alu_c5 = -1; srcb_c4 = -1;
        do_reset;
        for (int c = 1; c <= 20; c++) begin
            if (c > 1 && st == S_FETCH) begin
                len = c - 1;
                break;
            end
            if (rw) begin rw_n++; rw_cyc = c; rw_rd = int'(rd); rw_m2r = int'(m2r); end
            if (mw) begin
                if (mw_n == 0) mw_first = c;
                mw_n++; mw_last = c;
                if (iord) mw_iord++;
            end
            if (mr) mr_n++;
            if (epcw) begin epc_n++; epc_exc = int'(exc); end
            if (exo) begin xj_n++; xj_ok = int'(pcw && psrc == PCS_EXCVEC); end
            if (pcw && psrc == PCS_ALUOUT) br_n++;
            if (pcw && psrc == PCS_JUMP) jp_n++;
            if (c > 1 && pcw && psrc == PCS_ALURES) jr_n++;
            if (c == 4) srcb_c4 = int'(srcb);
            if (c == 5) alu_c5 = int'(alu);
            tick;
        end
    endtask

    initial begin
        // Reset state on both instances
        reset = 1'b0;
        tick;
        tick;
        check("rst_state_a", int'(a_st), int'(S_RST));
        check("rst_state_b", int'(b_st), int'(S_RST));
        check("rst_outs_a", int'(a_all), 0);
        check("rst_outs_b", int'(b_all), 0);

        // add, no overflow: writeback in cycle 6
        run(1'b0, OP_RTYPE, FN_ADD, 1'b0, 1'b0);
        check("add_len", len, 6);
        check("add_rw_n", rw_n, 1);
        check("add_rw_cyc", rw_cyc, 6);
        check("add_regdest", rw_rd, 1);
        check("add_memwrite", mw_n, 0);
        check("add_decode_srcb", srcb_c4, 3);
        check("add_aluctl", alu_c5, 1);

        // sub with overflow: exception path, cause 2
        run(1'b0, OP_RTYPE, FN_SUB, 1'b1, 1'b0);
        check("subovf_len", len, 9);
        check("subovf_rw_n", rw_n, 0);
        check("subovf_aluctl", alu_c5, 2);
        check("subovf_epc_n", epc_n, 1);
        check("subovf_exc", epc_exc, 2);
        check("subovf_jmp_ok", xj_ok, 1);

        // and ignores overflow
        run(1'b0, OP_RTYPE, FN_AND, 1'b1, 1'b0);
        check("and_len", len, 6);
        check("and_rw_n", rw_n, 1);
        check("and_aluctl", alu_c5, 3);

        // addi without and with overflow
        run(1'b0, OP_ADDI, 6'h00, 1'b0, 1'b0);
        check("addi_len", len, 6);
        check("addi_rw_n", rw_n, 1);
        check("addi_regdest", rw_rd, 0);
        run(1'b0, OP_ADDI, 6'h00, 1'b1, 1'b0);
        check("addiovf_len", len, 9);
        check("addiovf_rw_n", rw_n, 0);
        check("addiovf_exc", epc_exc, 2);
        check("addiovf_jmp_n", xj_n, 1);
        check("addiovf_jmp_ok", xj_ok, 1);

        // Branches
        run(1'b0, OP_BEQ, 6'h00, 1'b0, 1'b1);
        check("beq_z1_len", len, 5);
        check("beq_z1_taken", br_n, 1);
        run(1'b0, OP_BEQ, 6'h00, 1'b0, 1'b0);
        check("beq_z0_taken", br_n, 0);
        run(1'b0, OP_BNE, 6'h00, 1'b0, 1'b0);
        check("bne_z0_taken", br_n, 1);
        run(1'b0, OP_BNE, 6'h00, 1'b0, 1'b1);
        check("bne_z1_taken", br_n, 0);

        // Jumps
        run(1'b0, OP_J, 6'h00, 1'b0, 1'b0);
        check("j_len", len, 5);
        check("j_pcw", jp_n, 1);
        run(1'b0, OP_RTYPE, FN_JR, 1'b0, 1'b0);
        check("jr_len", len, 5);
        check("jr_pcw", jr_n, 1);

        // lw, MEM_WAIT=1
        run(1'b0, OP_LW, 6'h00, 1'b0, 1'b0);
        check("lw_len", len, 8);
        check("lw_rw_n", rw_n, 1);
        check("lw_rw_cyc", rw_cyc, 8);
        check("lw_memtoreg", rw_m2r, 1);
        check("lw_memread_n", mr_n, 2);

        // sw, MEM_WAIT=2
        run(1'b1, OP_SW, 6'h00, 1'b0, 1'b0);
        check("sw_len", len, 9);
        check("sw_mw_n", mw_n, 3);
        check("sw_mw_run", mw_last - mw_first + 1, 3);
        check("sw_iord", mw_iord, 3);
        check("sw_rw_n", rw_n, 0);

        // Invalid opcode and invalid FUNCT
        run(1'b0, 6'h3F, 6'h00, 1'b0, 1'b0);
        check("badop_len", len, 8);
        check("badop_rw_n", rw_n, 0);
        check("badop_exc", epc_exc, 1);
        check("badop_jmp_ok", xj_ok, 1);
        run(1'b0, OP_RTYPE, 6'h3F, 1'b0, 1'b0);
        check("badfn_len", len, 8);
        check("badfn_rw_n", rw_n, 0);
        check("badfn_exc", epc_exc, 1);

        // Reset in the middle of LW_RD
        sel = 1'b0; opcode = OP_LW; funct = 6'h00; ovf = 1'b0; zero = 1'b0;
        do_reset;
        begin
            int guard;
            guard = 0;
            while (a_st != S_LW_RD && guard < 12) begin
                tick;
                guard++;
            end
            check("mid_reach_lwrd", int'(a_st), int'(S_LW_RD));
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("mid_rst_state", int'(a_st), int'(S_RST));
            check("mid_rst_outs", int'(a_all), 0);
        end
        reset = 1'b1;
        tick;
        check("post_rst_state", int'(a_st), int'(S_FETCH));
        check("post_rst_pcw", int'(a_pcw), 1);
        check("post_rst_memread", int'(a_mr), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
